// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a shared capture register.
// Each grant writes one requester's data, then holds a settle window.
module reg_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 4,
  parameter int HOLD_CYCLES = 2,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         reg_q,
  output logic                      reg_we,
  output logic [IDW-1:0]            grant_id,
  output logic                      busy
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {IDLE, HOLD} state_e;

  state_e            state_q;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    ptr_d;
  logic [CW-1:0]     cnt_q;
  logic [IDW-1:0]    win;
  logic [IDW-1:0]    jw;
  logic              found;
  logic [DATA_W-1:0] win_data;
  int                j;

  // Scan from the far end so the index closest to ptr wins last.
  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    jw    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jw = IDW'(j);
      if (req_valid[jw]) begin
        win   = jw;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDW'(k) == win) win_data = req_data[k*DATA_W +: DATA_W];
    end
  end

  assign ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && found) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      reg_q    <= '0;
      reg_we   <= 1'b0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            reg_q    <= win_data;
            grant_id <= win;
            reg_we   <= 1'b1;
            ptr_q    <= ptr_d;
            if (HOLD_CYCLES > 0) begin
              state_q <= HOLD;
              cnt_q   <= CW'(HOLD_CYCLES - 1);
              busy    <= 1'b1;
            end
          end else begin
            reg_we <= 1'b0;
          end
        end
        HOLD: begin
          reg_we <= 1'b0;
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed vector bench for reg_write_arbiter.
// Main instance uses HOLD_CYCLES=2, a second one HOLD_CYCLES=0.
module tb_reg_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  reg_q;
  logic        reg_we;
  logic [1:0]  grant_id;
  logic        busy;

  logic [3:0]  v0;
  logic [15:0] d0;
  logic [3:0]  rdy0;
  logic [3:0]  rq0;
  logic        we0;
  logic [1:0]  gid0;
  logic        bsy0;

  int checks = 0;
  int errors = 0;

  reg_write_arbiter #(.NUM_REQ(4), .DATA_W(4), .HOLD_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .reg_q(reg_q), .reg_we(reg_we),
    .grant_id(grant_id), .busy(busy)
  );

  reg_write_arbiter #(.NUM_REQ(4), .DATA_W(4), .HOLD_CYCLES(0)) u_h0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v0), .req_data(d0),
    .req_ready(rdy0), .reg_q(rq0), .reg_we(we0),
    .grant_id(gid0), .busy(bsy0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  v;
    logic [15:0] d;
    logic [3:0]  rdy;
    logic [3:0]  rq;
    logic        we;
    logic [1:0]  gid;
    logic        bsy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic [3:0] v, logic [15:0] d, logic [3:0] rdy,
                              logic [3:0] rq, logic we, logic [1:0] gid,
                              logic bsy);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.rq = rq;
    r.we = we; r.gid = gid; r.bsy = bsy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic [3:0] rq,
                          input logic we, input logic [1:0] gid,
                          input logic bsy);
    chk({tag, ".reg_q"}, 32'(reg_q), 32'(rq));
    chk({tag, ".reg_we"}, 32'(reg_we), 32'(we));
    chk({tag, ".grant_id"}, 32'(grant_id), 32'(gid));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
  endtask

  initial begin
    // all four valid, data 1..4, starting from ptr=0
    for (int r = 0; r < 5; r++) begin
      logic [3:0] oh;
      logic [3:0] val;
      logic [1:0] g;
      g   = 2'(r % 4);
      oh  = 4'b0001 << g;
      val = 4'(g) + 4'd1;
      tv.push_back(mk(4'b1111, 16'h4321, oh,    val, 1'b1, g, 1'b1));
      tv.push_back(mk(4'b1111, 16'h4321, 4'b0, val, 1'b0, g, 1'b1));
      tv.push_back(mk(4'b1111, 16'h4321, 4'b0, val, 1'b0, g, 1'b0));
    end
    // pointer wrap: grant 1, then 1001 -> 3 wins, then 0
    tv.push_back(mk(4'b0010, 16'h4321, 4'b0010, 4'h2, 1'b1, 2'd1, 1'b1));
    tv.push_back(mk(4'b1001, 16'h4321, 4'b0000, 4'h2, 1'b0, 2'd1, 1'b1));
    tv.push_back(mk(4'b1001, 16'h4321, 4'b0000, 4'h2, 1'b0, 2'd1, 1'b0));
    tv.push_back(mk(4'b1001, 16'h4321, 4'b1000, 4'h4, 1'b1, 2'd3, 1'b1));
    tv.push_back(mk(4'b1001, 16'h4321, 4'b0000, 4'h4, 1'b0, 2'd3, 1'b1));
    tv.push_back(mk(4'b1001, 16'h4321, 4'b0000, 4'h4, 1'b0, 2'd3, 1'b0));
    tv.push_back(mk(4'b1001, 16'h4321, 4'b0001, 4'h1, 1'b1, 2'd0, 1'b1));
    tv.push_back(mk(4'b1001, 16'h4321, 4'b0000, 4'h1, 1'b0, 2'd0, 1'b1));
    tv.push_back(mk(4'b0000, 16'h4321, 4'b0000, 4'h1, 1'b0, 2'd0, 1'b0));
    // single requester 2 with data A, ptr=1
    tv.push_back(mk(4'b0100, 16'h5A73, 4'b0100, 4'hA, 1'b1, 2'd2, 1'b1));
    tv.push_back(mk(4'b0100, 16'h5A73, 4'b0000, 4'hA, 1'b0, 2'd2, 1'b1));
    tv.push_back(mk(4'b0100, 16'h5A73, 4'b0000, 4'hA, 1'b0, 2'd2, 1'b0));
    tv.push_back(mk(4'b0100, 16'h5A73, 4'b0100, 4'hA, 1'b1, 2'd2, 1'b1));
    tv.push_back(mk(4'b0000, 16'hFFFF, 4'b0000, 4'hA, 1'b0, 2'd2, 1'b1));
    tv.push_back(mk(4'b0000, 16'hFFFF, 4'b0000, 4'hA, 1'b0, 2'd2, 1'b0));
    tv.push_back(mk(4'b0000, 16'h0000, 4'b0000, 4'hA, 1'b0, 2'd2, 1'b0));

    rst_n     = 1'b1;
    req_valid = 4'(`ifdef NEVER 0 `else $urandom `endif);
    req_data  = 16'($urandom);
    v0        = 4'(4'hF & $urandom);
    d0        = 16'($urandom);
    #2 rst_n = 1'b0;
    #1;
    chk("reset.req_ready", 32'(req_ready), 32'h0);
    chk_regs("reset", 4'h0, 1'b0, 2'd0, 1'b0);
    chk("reset.h0_busy", 32'(bsy0), 32'h0);

    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    v0        = 4'b0000;
    #2 rst_n = 1'b1;
    step();

    foreach (tv[i]) begin
      req_valid = tv[i].v;
      req_data  = tv[i].d;
      #1;
      chk($sformatf("v%0d.req_ready", i), 32'(req_ready), 32'(tv[i].rdy));
      step();
      chk_regs($sformatf("v%0d", i), tv[i].rq, tv[i].we, tv[i].gid,
               tv[i].bsy);
    end

    // reset in the second HOLD cycle (ptr=3 here)
    req_valid = 4'b1111;
    req_data  = 16'h4321;
    #1;
    chk("mh.req_ready", 32'(req_ready), 32'b1000);
    step();
    chk_regs("mh.xfer", 4'h4, 1'b1, 2'd3, 1'b1);
    step();
    chk_regs("mh.hold2", 4'h4, 1'b0, 2'd3, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_regs("mh.rst", 4'h0, 1'b0, 2'd0, 1'b0);
    chk("mh.rst_ready", 32'(req_ready), 32'h0);
    #2 rst_n = 1'b1;
    #1;
    chk("mh.post_ready", 32'(req_ready), 32'b0001);
    step();
    chk_regs("mh.post", 4'h1, 1'b1, 2'd0, 1'b1);
    req_valid = 4'b0000;

    // zero-hold instance: back-to-back alternating grants
    v0 = 4'b0011;
    d0 = 16'h0021;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] g;
      g = 2'(i % 2);
      #1;
      chk($sformatf("h0_%0d.req_ready", i), 32'(rdy0), 32'(4'b0001 << g));
      step();
      chk($sformatf("h0_%0d.reg_q", i), 32'(rq0), 32'(g) + 32'd1);
      chk($sformatf("h0_%0d.reg_we", i), 32'(we0), 32'd1);
      chk($sformatf("h0_%0d.grant_id", i), 32'(gid0), 32'(g));
      chk($sformatf("h0_%0d.busy", i), 32'(bsy0), 32'd0);
    end
    v0 = 4'b0000;
    #1;
    step();
    chk("h0_idle.reg_we", 32'(we0), 32'd0);
    chk("h0_idle.reg_q", 32'(rq0), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared DATA_W-bit capture register: the single write port in front of a clocked register.
- Up to NUM_REQ requesters compete for the register through valid/ready handshakes. One winner is written per grant.
- After each write, the register is held busy for HOLD_CYCLES cycles (settle window) before it accepts the next write.
- Sits between producer blocks and the shared register; owns the register contents and the round-robin priority pointer.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
DATA_W, 4, width of the shared register and of each request datum
HOLD_CYCLES, 2, busy cycles after each write (0 = back-to-back writes allowed)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester write request
req_data  input  NUM_REQ*DATA_W  requester k data at bits [k*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant; transfer when valid&ready at clock edge
reg_q  output  DATA_W  current shared register value
reg_we  output  1  one-cycle pulse, high in the cycle after a transfer (reg_q holds the new value)
grant_id  output  max(1,$clog2(NUM_REQ))  index of the last granted requester
busy  output  1  high while in HOLD

Behaviour:
- Reset (rst_n low, asynchronous):
  - reg_q=0, reg_we=0, grant_id=0, busy=0, req_ready=0.
  - Round-robin pointer ptr=0, state IDLE, hold counter=0.
  - Takes effect immediately, including mid-HOLD; any hold in progress is abandoned.
- States:
  - IDLE: accepting writes.
  - HOLD: register settling; no grants.
- IDLE, request selection:
  - req_ready is combinational.
  - Winner k = first index with req_valid[k]=1, searching ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
  - req_ready has exactly bit k set; all zero if no valid.
- IDLE, on a clock edge with a transfer (req_valid[k]&req_ready[k]):
  - reg_q <= req_data[k]; grant_id <= k; reg_we <= 1.
  - ptr <= (k+1) mod NUM_REQ.
  - If HOLD_CYCLES>0: state <= HOLD, counter <= HOLD_CYCLES-1, busy <= 1.
  - If HOLD_CYCLES=0: remain IDLE.
- IDLE with no valid: ptr unchanged, reg_we <= 0.
- HOLD:
  - req_ready=0 for all requesters; reg_we <= 0.
  - If counter==0: state <= IDLE, busy <= 0. Otherwise counter decrements.
  - HOLD therefore lasts exactly HOLD_CYCLES cycles.
- Throughput: one write per HOLD_CYCLES+1 cycles.
- reg_we is never high on two consecutive cycles unless HOLD_CYCLES=0.
- Requests are not latched:
  - A requester may drop req_valid before being granted; no state changes.
  - Data is sampled only at the transfer edge.
- Simultaneous requests are resolved only by ptr. A requester that keeps requesting is served within NUM_REQ grants (no starvation).
- NUM_REQ=1: ptr is constant 0; grant_id is 1 bit, always 0.
- No other outputs change outside transfers; reg_q holds its value indefinitely.

Test Plan:
- Reset: rst_n=0 with random req_valid/req_data -> reg_q=0, reg_we=0, grant_id=0, busy=0, req_ready=0000.
- Single requester (NUM_REQ=4, DATA_W=4, HOLD_CYCLES=2): req_valid=0100, data[2]=0xA held high ->
  - req_ready=0100 in IDLE.
  - After the edge: reg_q=0xA, grant_id=2, reg_we=1 for one cycle, busy=1 for 2 cycles.
  - Next req_ready=0100 exactly 3 cycles after the first transfer.
- All four valid continuously with data 1,2,3,4 -> grant_id sequence 0,1,2,3,0; reg_q sequence 1,2,3,4,1; transfers spaced 3 cycles apart.
- Pointer wrap: after a grant to 1 (ptr=2), assert req_valid=1001 -> requester 3 wins (reg_q=data[3]); the next grant goes to 0.
- Reset mid-HOLD: assert rst_n=0 in the second HOLD cycle -> busy, reg_q, reg_we, grant_id drop to 0 immediately. After release, in IDLE with ptr=0: req_valid=1111 grants requester 0 on the first cycle.
- HOLD_CYCLES=0: two requesters continuously valid -> transfers on consecutive cycles alternating 0,1; reg_we high every cycle; busy stays 0.
